// File: rtl/pq_pkg.sv
// pq_pkg: definitions shared by the priority-queue autotest.
//   at_state_t - autotest run states, encoded as they appear on the state output
//   lfsr_taps  - maximal-length Galois (right-shift) feedback masks for widths 4..16
//   kv_width   - width of a queue entry; an entry is {key, value}, with the key in the MSBs
package pq_pkg;

  typedef enum logic [2:0] {
    AT_IDLE  = 3'd0,
    AT_FILL  = 3'd1,
    AT_DRAIN = 3'd2,
    AT_DONE  = 3'd3,
    AT_FAIL  = 3'd4
  } at_state_t;

  localparam int KW_MIN = 4;
  localparam int KW_MAX = 16;

  function automatic int kv_width(input int kw, input int vw);
    return kw + vw;
  endfunction

  // Bit k of the mask is XORed into the register when the bit shifted out of bit 0 is 1.
  function automatic logic [KW_MAX-1:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h0009;
      5:       return 16'h0012;
      6:       return 16'h0021;
      7:       return 16'h0041;
      8:       return 16'h008E;
      9:       return 16'h0108;
      10:      return 16'h0204;
      11:      return 16'h0402;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h4001;
      default: return 16'h8016;
    endcase
  endfunction

endpackage

// File: rtl/pq_autotest_if.sv
// pq_autotest_if: the client-side handshake of the priority queue.
//   full, empty, busy - queue status
//   kvo               - queue head {key, value}; valid whenever !empty
//   enq, deq          - one-cycle enqueue/dequeue strobes
//   kvi               - {key, value} to enqueue
// The master modport is the traffic generator. The slave modport is the queue.
interface pq_autotest_if
  import pq_pkg::*;
#(
  parameter int KW = 8,
  parameter int VW = 8
);
  logic                        full;
  logic                        empty;
  logic                        busy;
  logic [kv_width(KW,VW)-1:0]  kvo;
  logic                        enq;
  logic                        deq;
  logic [kv_width(KW,VW)-1:0]  kvi;

  modport master (input full, empty, busy, kvo, output enq, deq, kvi);
  modport slave  (output full, empty, busy, kvo, input enq, deq, kvi);
endinterface

// File: rtl/lfsr_n.sv
// lfsr_n: Galois right-shift LFSR of parameterised width.
//   clk  - clock
//   rst  - synchronous active-high reset; clears the register to 0
//   load - loads SEED; takes priority over enb
//   enb  - advances the register by one step
//   q    - current LFSR state
module lfsr_n #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enb,
  output logic [WIDTH-1:0] q
);

  // NOTE: clocked state uses non-blocking assignments, so every register in the design samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= SEED;
    else if (enb)  q <= (q >> 1) ^ (q[0] ? TAPS : '0);
  end

endmodule

// File: rtl/pq_autotest.sv
// pq_autotest: self-checking fill/drain traffic generator for the priority queue.
//   clk, rst             - clock; synchronous active-high reset
//   start                - level; a run begins when start is high in IDLE
//   pq (master)          - queue handshake: full/empty/busy/kvo in, enq/deq/kvi out
//   state                - IDLE=0, FILL=1, DRAIN=2, DONE=3, FAIL=4
//   done, pass           - run finished / run finished with zero errors
//   err_count            - saturating error count
//   enq_count, deq_count - items accepted this run
// Build option: define PQ_AUTOTEST_CHECKSUM_EN to XOR-accumulate every enqueued kvi and every
// dequeued kvo. A nonzero residue at DRAIN->DONE counts as one error.
module pq_autotest
  import pq_pkg::*;
#(
  parameter int KW        = 8,
  parameter int VW        = 8,
  parameter int NUM_ITEMS = 16,
  parameter bit MIN_FIRST = 1'b1,
  parameter int LFSR_SEED = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  pq_autotest_if.master        pq,
  output logic [2:0]           state,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [15:0]          enq_count,
  output logic [15:0]          deq_count
);

  localparam int               IW       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int               TW       = $clog2(TIMEOUT + 1);
  localparam int               VW1      = VW + 1;
  localparam logic [16:0]      N_ITEMS  = 17'(NUM_ITEMS);
  localparam logic [VW:0]      N_VAL    = VW1'(NUM_ITEMS);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [KW_MAX-1:0] TAPS_ALL = lfsr_taps(KW);

  at_state_t             state_q, state_d;
  logic [15:0]           enq_count_q, deq_count_q, err_count_q;
  logic [KW-1:0]         prev_key_q;
  logic                  have_prev_q;
  logic [NUM_ITEMS-1:0]  seen_q;
  logic [TW-1:0]         idle_cnt_q;
  logic [KW-1:0]         lfsr_q;

  logic                  run_init, enq_c, deq_c, err_any;
  logic                  order_bad, val_oor, seen_bad, stalled, chk_bad;
  logic [KW-1:0]         deq_key;
  logic [VW-1:0]         deq_val;
  logic [IW-1:0]         seen_idx;

  lfsr_n #(
    .WIDTH (KW),
    .TAPS  (TAPS_ALL[KW-1:0]),
    .SEED  (KW'(LFSR_SEED))
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (run_init),
    .enb  (enq_c),
    .q    (lfsr_q)
  );

  // The key comes from the LFSR and the value is the item's sequence number, so every value is unique.
  assign pq.kvi = {lfsr_q, enq_count_q[VW-1:0]};
  assign pq.enq = enq_c;
  assign pq.deq = deq_c;

  assign deq_key   = pq.kvo[KW+VW-1:VW];
  assign deq_val   = pq.kvo[VW-1:0];
  assign seen_idx  = deq_val[IW-1:0];
  assign order_bad = have_prev_q && (MIN_FIRST ? (deq_key < prev_key_q) : (deq_key > prev_key_q));
  assign val_oor   = ({1'b0, deq_val} >= N_VAL);
  assign seen_bad  = val_oor || seen_q[seen_idx];
  assign stalled   = (idle_cnt_q >= TO_LAST);

`ifdef PQ_AUTOTEST_CHECKSUM_EN
  logic [KW+VW-1:0] chk_q;

  always_ff @(posedge clk) begin
    if (rst || run_init) chk_q <= '0;
    else if (enq_c)      chk_q <= chk_q ^ pq.kvi;
    else if (deq_c)      chk_q <= chk_q ^ pq.kvo;
  end

  assign chk_bad = (chk_q != '0);
`else
  assign chk_bad = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    run_init = 1'b0;
    enq_c    = 1'b0;
    deq_c    = 1'b0;
    err_any  = 1'b0;
    unique case (state_q)
      AT_IDLE: begin
        if (start) begin
          state_d  = AT_FILL;
          run_init = 1'b1;
        end
      end
      AT_FILL: begin
        enq_c = !pq.full && !pq.busy && ({1'b0, enq_count_q} < N_ITEMS);
        if ({1'b0, enq_count_q} >= N_ITEMS) begin
          state_d = AT_DRAIN;
        end else if (pq.full) begin
          state_d = AT_DRAIN;
          err_any = 1'b1;
        end else if (stalled && !enq_c) begin
          state_d = AT_FAIL;
          err_any = 1'b1;
        end
      end
      AT_DRAIN: begin
        deq_c = !pq.empty && !pq.busy;
        if (deq_c) begin
          err_any = order_bad || seen_bad;
        end else if (pq.empty && !pq.busy) begin
          state_d = AT_DONE;
          err_any = (deq_count_q != enq_count_q) || chk_bad;
        end else if (stalled) begin
          state_d = AT_FAIL;
          err_any = 1'b1;
        end
      end
      AT_DONE, AT_FAIL: begin
        if (!start) state_d = AT_IDLE;
      end
      default: state_d = AT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= AT_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the seen bitmap is cleared by reset and again at every run start, because the duplicate check reads it.
  always_ff @(posedge clk) begin
    if (rst || run_init) begin
      enq_count_q <= '0;
      deq_count_q <= '0;
      err_count_q <= '0;
      prev_key_q  <= '0;
      have_prev_q <= 1'b0;
      seen_q      <= '0;
      idle_cnt_q  <= '0;
    end else begin
      if (enq_c) enq_count_q <= enq_count_q + 16'd1;
      if (deq_c) begin
        deq_count_q <= deq_count_q + 16'd1;
        prev_key_q  <= deq_key;
        have_prev_q <= 1'b1;
        if (!val_oor) seen_q[seen_idx] <= 1'b1;
      end
      // Several errors in one cycle count once. The count sticks at all-ones.
      if (err_any && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
      if ((state_q == AT_FILL || state_q == AT_DRAIN) && !(enq_c || deq_c))
        idle_cnt_q <= idle_cnt_q + TW'(1);
      else
        idle_cnt_q <= '0;
    end
  end

  assign state     = state_q;
  assign done      = (state_q == AT_DONE) || (state_q == AT_FAIL);
  assign pass      = (state_q == AT_DONE) && (err_count_q == 16'd0);
  assign err_count = err_count_q;
  assign enq_count = enq_count_q;
  assign deq_count = deq_count_q;

endmodule

// File: tb/tb_pq_autotest.sv
// tb_pq_autotest: directed scenarios for pq_autotest with the default parameters
// (KW=8, VW=8, NUM_ITEMS=16, MIN_FIRST=1, LFSR_SEED=1, TIMEOUT=1024).
// A behavioural queue model answers the handshake. It can serve minimum-first (the ideal
// queue) or maximum-first, repeat one item, report full early, stall on busy, or assert
// busy at random. Expected kvi streams and error counts are derived from the run rules.
module tb_pq_autotest;

  localparam int  N        = 16;
  localparam int  SEED     = 1;
  localparam int  DUP_AT   = 5;
  localparam int  M_MIN    = 0;
  localparam int  M_MAX    = 1;
  localparam int  M_DUP    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  state;
  logic        done, pass;
  logic [15:0] err_count, enq_count, deq_count;

  pq_autotest_if #(.KW(8), .VW(8)) pq_bus ();

  pq_autotest dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pq        (pq_bus.master),
    .state     (state),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .enq_count (enq_count),
    .deq_count (deq_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural queue model ----------------
  int          mode       = M_MIN;
  int          cap        = 1000;
  int          busy_after = 0;
  bit          rand_busy  = 1'b0;
  logic [15:0] mq[$];
  logic [15:0] enq_log[$];
  logic [15:0] deq_log[$];

  function automatic int head_idx();
    int h = 0;
    for (int i = 1; i < mq.size(); i++) begin
      if (mode == M_MAX) begin
        if (mq[i][15:8] > mq[h][15:8]) h = i;
      end else begin
        if (mq[i][15:8] < mq[h][15:8]) h = i;
      end
    end
    return h;
  endfunction

  always @(posedge clk) begin
    int h;
    if (rst) begin
      mq.delete();
      enq_log.delete();
      deq_log.delete();
      pq_bus.full  <= 1'b0;
      pq_bus.empty <= 1'b1;
      pq_bus.busy  <= 1'b0;
      pq_bus.kvo   <= '0;
    end else begin
      if (pq_bus.deq && mq.size() > 0) begin
        h = head_idx();
        deq_log.push_back(pq_bus.kvo);
        if (!(mode == M_DUP && deq_log.size() == DUP_AT)) mq.delete(h);
      end
      if (pq_bus.enq) begin
        mq.push_back(pq_bus.kvi);
        enq_log.push_back(pq_bus.kvi);
      end
      pq_bus.full  <= (mq.size() >= cap);
      pq_bus.empty <= (mq.size() == 0);
      pq_bus.busy  <= (busy_after > 0 && enq_log.size() >= busy_after) ||
                      (rand_busy && $urandom_range(3) == 0);
      pq_bus.kvo   <= (mq.size() > 0) ? mq[head_idx()] : 16'h0000;
    end
  end

  // ---------------- reference rules ----------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    // x^8 + x^4 + x^3 + x^2 + 1, right-shifting Galois form
    return (x >> 1) ^ (x[0] ? 8'h8E : 8'h00);
  endfunction

  function automatic logic [15:0] exp_kvi(input int idx);
    logic [7:0] l = 8'(SEED);
    logic [7:0] v = idx[7:0];
    for (int i = 0; i < idx; i++) l = lfsr_step(l);
    return {l, v};
  endfunction

  // Errors the run should report, given what the queue actually handed out.
  function automatic int exp_errors();
    int         e = 0;
    bit         seen [256];
    logic [7:0] prev = 8'h00;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < deq_log.size(); i++) begin
      logic [7:0] k = deq_log[i][15:8];
      logic [7:0] v = deq_log[i][7:0];
      bit bad = 1'b0;
      if (i > 0 && k < prev) bad = 1'b1;
      if (int'(v) >= N || seen[v]) bad = 1'b1;
      seen[v] = 1'b1;
      prev = k;
      if (bad) e++;
    end
    if (enq_log.size() < N) e++;
    if (deq_log.size() != enq_log.size()) e++;
    return e;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input int n);
    check({tag, "_enq_len"}, enq_log.size(), n);
    for (int i = 0; i < n && i < enq_log.size(); i++)
      check({tag, "_kvi"}, enq_log[i], exp_kvi(i));
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run(input int budget, input bit drop_start, output int edges);
    start = 1'b1;
    edges = 0;
    while (done !== 1'b1 && edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (drop_start && edges == 5) start = 1'b0;
    end
    check("run_done", done, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_enq_count"}, enq_count, 0);
    check({tag, "_deq_count"}, deq_count, 0);
    check({tag, "_kvi"}, pq_bus.kvi, 0);
    check({tag, "_enq"}, pq_bus.enq, 0);
    check({tag, "_deq"}, pq_bus.deq, 0);
  endtask

  initial begin
    int edges;
    int k;
    int m;

    rst   = 1'b1;
    start = 1'b0;
    do_reset();
    check_reset_values("rst");

    // Ideal min-queue: fixed run length, clean pass.
    run(200, 1'b0, edges);
    check("ideal_cycles", edges, 35);
    check("ideal_state", state, 3);
    check("ideal_pass", pass, 1);
    check("ideal_err", err_count, 0);
    check("ideal_enq_count", enq_count, N);
    check("ideal_deq_count", deq_count, N);
    check("ideal_err_model", err_count, exp_errors());
    check_stream("ideal", N);
    repeat (3) begin @(posedge clk); #1; end
    check("done_holds_while_start", state, 3);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_to_idle", state, 0);
    check("idle_done_low", done, 0);

    // Random busy stalls, start released mid-run: still a clean pass with the same keys.
    do_reset();
    rand_busy = 1'b1;
    run(3000, 1'b1, edges);
    rand_busy = 1'b0;
    check("rbusy_pass", pass, 1);
    check("rbusy_err", err_count, 0);
    check("rbusy_enq_count", enq_count, N);
    check("rbusy_deq_count", deq_count, N);
    check("rbusy_min_cycles", edges >= 35, 1);
    check_stream("rbusy", N);
    @(posedge clk); #1;
    check("rbusy_idle", state, 0);

    // Max-first queue: every later dequeue is out of order.
    do_reset();
    mode = M_MAX;
    run(200, 1'b0, edges);
    check("max_pass", pass, 0);
    check("max_done", done, 1);
    check("max_err_model", err_count, exp_errors());
    check("max_err", err_count, N - 1);

    // One item returned twice: duplicate value plus count mismatch.
    do_reset();
    mode = M_DUP;
    run(200, 1'b0, edges);
    check("dup_pass", pass, 0);
    check("dup_err", err_count, 2);
    check("dup_err_model", err_count, exp_errors());
    check("dup_deq_count", deq_count, N + 1);
    check("dup_enq_count", enq_count, N);

    // Queue reports full after 10 items.
    do_reset();
    mode = M_MIN;
    cap  = 10;
    run(200, 1'b0, edges);
    cap  = 1000;
    check("full_enq_count", enq_count, 10);
    check("full_deq_count", deq_count, 10);
    check("full_err", err_count, 1);
    check("full_err_model", err_count, exp_errors());
    check("full_pass", pass, 0);
    check("full_state", state, 3);

    // busy stuck high after 3 enqueues: FAIL after TIMEOUT idle cycles.
    do_reset();
    busy_after = 3;
    start = 1'b1;
    k = 0;
    while (enq_log.size() < 3 && k < 50) begin @(posedge clk); #1; k++; end
    check("to_three_enq", enq_log.size(), 3);
    m = 0;
    while (state !== 3'd4 && m < 1500) begin @(posedge clk); #1; m++; end
    check("to_latency", m, 1024);
    check("to_state", state, 4);
    check("to_done", done, 1);
    check("to_pass", pass, 0);
    check("to_enq", pq_bus.enq, 0);
    check("to_err", err_count, 1);
    start = 1'b0;
    @(posedge clk); #1;
    check("fail_to_idle", state, 0);
    busy_after = 0;

    // Reset in the middle of DRAIN with start held high: next run is a fresh run.
    do_reset();
    start = 1'b1;
    k = 0;
    while (!(state === 3'd2 && deq_log.size() >= 3) && k < 100) begin @(posedge clk); #1; k++; end
    check("mid_in_drain", state, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("mid_rst");
    rst = 1'b0;
    run(200, 1'b0, edges);
    check("rerun_cycles", edges, 35);
    check("rerun_pass", pass, 1);
    check("rerun_err", err_count, 0);
    check("rerun_deq_count", deq_count, N);
    check_stream("rerun", N);
    start = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
